// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser that drives note number, velocity and gate for a single voice.
// Define OMNI_MODE_EN to accept note messages on all 16 channels instead of only CHANNEL.
module midi_note_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] MIDI_freq,
  output logic [6:0] volume,
  output logic       gate,
  output logic       note_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_status;
  logic [3:0] r_chan;
  logic [6:0] r_d1;
  logic [6:0] r_freq;
  logic [6:0] r_vol;
  logic       r_gate;
  logic       r_note_valid;

  logic w_cls_data;
  logic w_cls_chan;
  logic w_cls_sys;
  logic w_one_byte;
  logic w_done2;
  logic w_chan_ok;
  logic w_is_on;
  logic w_is_off;
  logic w_note_on;
  logic w_note_off;

  // Byte classification and note-event decode for the byte currently presented
  always_comb begin
    w_cls_data = 1'b0;
    w_cls_chan = 1'b0;
    w_cls_sys  = 1'b0;
    if (rx_data[7] == 1'b0) begin
      w_cls_data = 1'b1;
    end else if (rx_data[7:4] != 4'hF) begin
      w_cls_chan = 1'b1;
    end else if (rx_data[3] == 1'b0) begin
      w_cls_sys = 1'b1;
    end else begin
      w_cls_data = 1'b0;
    end

    w_one_byte = (r_status == 4'hC) || (r_status == 4'hD);
    w_done2    = rx_valid && w_cls_data && (r_state == S_WAIT_D2);

`ifdef OMNI_MODE_EN
    w_chan_ok = 1'b1;
`else
    w_chan_ok = (r_chan == CHANNEL);
`endif

    // Note On with zero velocity is a Note Off
    w_is_on  = (r_status == 4'h9) && (rx_data[6:0] != 7'd0);
    w_is_off = (r_status == 4'h8) || ((r_status == 4'h9) && (rx_data[6:0] == 7'd0));

    w_note_on  = w_done2 && w_chan_ok && w_is_on;
    w_note_off = w_done2 && w_chan_ok && w_is_off && r_gate && (r_d1 == r_freq);
  end

  // Parser FSM, running-status latch and registered voice outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_status     <= 4'd0;
      r_chan       <= 4'd0;
      r_d1         <= 7'd0;
      r_freq       <= 7'd69;
      r_vol        <= 7'd0;
      r_gate       <= 1'b0;
      r_note_valid <= 1'b0;
    end else begin
      r_note_valid <= 1'b0;
      if (rx_valid) begin
        if (w_cls_chan) begin
          r_status <= rx_data[7:4];
          r_chan   <= rx_data[3:0];
          r_state  <= S_WAIT_D1;
        end else if (w_cls_sys) begin
          r_status <= 4'd0;
          r_chan   <= 4'd0;
          r_state  <= (rx_data[2:0] == 3'd0) ? S_SYSEX : S_IDLE;
        end else if (w_cls_data) begin
          case (r_state)
            S_WAIT_D1: begin
              if (!w_one_byte) begin
                r_d1    <= rx_data[6:0];
                r_state <= S_WAIT_D2;
              end else begin
                r_state <= S_WAIT_D1;
              end
            end
            S_WAIT_D2: r_state <= S_WAIT_D1;
            S_IDLE:    r_state <= S_IDLE;
            S_SYSEX:   r_state <= S_SYSEX;
            default:   r_state <= S_IDLE;
          endcase
        end else begin
          // Real-time bytes leave everything untouched, even mid-message
          r_state <= r_state;
        end
      end

      if (w_note_on) begin
        r_freq       <= r_d1;
        r_vol        <= rx_data[6:0];
        r_gate       <= 1'b1;
        r_note_valid <= 1'b1;
      end else if (w_note_off) begin
        r_gate       <= 1'b0;
        r_note_valid <= 1'b1;
      end else begin
        r_gate <= r_gate;
      end
    end
  end

  assign MIDI_freq  = r_freq;
  assign volume     = r_vol;
  assign gate       = r_gate;
  assign note_valid = r_note_valid;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Self-checking bench for midi_note_decoder: directed vector table, reset and channel
// sequences, then random byte streams checked against a message-level reference model.
module tb_midi_note_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] MIDI_freq;
  logic [6:0] volume;
  logic       gate;
  logic       note_valid;

  int n_vec;
  int n_bad;

  midi_note_decoder #(.CHANNEL(4'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .MIDI_freq  (MIDI_freq),
    .volume     (volume),
    .gate       (gate),
    .note_valid (note_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: running status plus a buffer of collected data bytes
  int         m_rs;
  logic [6:0] m_q[$];
  logic [6:0] m_freq;
  logic [6:0] m_vol;
  logic       m_gate;
  logic       m_nv;

  task automatic model_reset();
    m_rs = -1;
    m_q.delete();
    m_freq = 7'd69;
    m_vol  = 7'd0;
    m_gate = 1'b0;
    m_nv   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int hi;
    int ch;
    int need;
    bit ok;
    if (b >= 8'hF8) begin
      // real-time: no effect
    end else if (b >= 8'hF0) begin
      m_rs = -1;
      m_q.delete();
    end else if (b >= 8'h80) begin
      m_rs = int'(b);
      m_q.delete();
    end else if (m_rs >= 0) begin
      m_q.push_back(b[6:0]);
      hi   = m_rs / 16;
      ch   = m_rs % 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (m_q.size() == need) begin
`ifdef OMNI_MODE_EN
        ok = 1'b1;
`else
        ok = (ch == 0);
`endif
        if (ok && need == 2) begin
          if (hi == 9 && m_q[1] != 7'd0) begin
            m_freq = m_q[0];
            m_vol  = m_q[1];
            m_gate = 1'b1;
            m_nv   = 1'b1;
          end else if ((hi == 8 || hi == 9) && m_gate && m_q[0] == m_freq) begin
            m_gate = 1'b0;
            m_nv   = 1'b1;
          end
        end
        m_q.delete();
      end
    end
  endtask

  task automatic apply(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    m_nv     = 1'b0;
    if (v) model_byte(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] f, input logic [6:0] vol,
                     input logic g, input logic nv);
    n_vec++;
    if (MIDI_freq !== f || volume !== vol || gate !== g || note_valid !== nv) begin
      n_bad++;
      $display("FAIL %s: got freq=%h vol=%h gate=%b nv=%b, want freq=%h vol=%h gate=%b nv=%b",
               name, MIDI_freq, volume, gate, note_valid, f, vol, g, nv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #1;
    chk("reset_now", 7'd69, 7'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [6:0] f;
    logic [6:0] vol;
    logic       g;
    logic       nv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic [6:0] f,
                     input logic [6:0] vol, input logic g, input logic nv);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.vol = vol; t.g = g; t.nv = nv;
    tbl.push_back(t);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 30)      b = 8'h3C + 8'($urandom_range(0, 3));
    else if (r < 38) b = 8'h00;
    else if (r < 45) b = 8'($urandom_range(0, 127));
    else if (r < 58) b = 8'h90 | 8'($urandom_range(0, 1));
    else if (r < 68) b = 8'h80 | 8'($urandom_range(0, 1));
    else if (r < 73) b = ($urandom_range(0, 1) == 0) ? 8'hC0 : 8'hD0;
    else if (r < 76) b = 8'hB0;
    else if (r < 86) b = 8'hF8 + 8'($urandom_range(0, 7));
    else if (r < 89) b = 8'hF0;
    else if (r < 92) b = 8'hF1 + 8'($urandom_range(0, 6));
    else             b = 8'($urandom_range(0, 127));
    return b;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2;
    do_reset();

    // basic note on
    add(1'b1, 8'h90, 7'h45, 7'h00, 1'b0, 1'b0);
    add(1'b1, 8'h45, 7'h45, 7'h00, 1'b0, 1'b0);
    add(1'b1, 8'h64, 7'h45, 7'h64, 1'b1, 1'b1);
    add(1'b0, 8'h22, 7'h45, 7'h64, 1'b1, 1'b0);
    // running status, two notes
    add(1'b1, 8'h90, 7'h45, 7'h64, 1'b1, 1'b0);
    add(1'b1, 8'h3C, 7'h45, 7'h64, 1'b1, 1'b0);
    add(1'b1, 8'h50, 7'h3C, 7'h50, 1'b1, 1'b1);
    add(1'b1, 8'h40, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h30, 7'h40, 7'h30, 1'b1, 1'b1);
    // non-matching note off, then velocity-0 note on releases
    add(1'b1, 8'h90, 7'h40, 7'h30, 1'b1, 1'b0);
    add(1'b1, 8'h3C, 7'h40, 7'h30, 1'b1, 1'b0);
    add(1'b1, 8'h50, 7'h3C, 7'h50, 1'b1, 1'b1);
    add(1'b1, 8'h80, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h3E, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h00, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h90, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h3C, 7'h3C, 7'h50, 1'b1, 1'b0);
    add(1'b1, 8'h00, 7'h3C, 7'h50, 1'b0, 1'b1);
    // real-time bytes interleaved
    add(1'b1, 8'h90, 7'h3C, 7'h50, 1'b0, 1'b0);
    add(1'b1, 8'hF8, 7'h3C, 7'h50, 1'b0, 1'b0);
    add(1'b1, 8'h30, 7'h3C, 7'h50, 1'b0, 1'b0);
    add(1'b1, 8'hFE, 7'h3C, 7'h50, 1'b0, 1'b0);
    add(1'b1, 8'h7F, 7'h30, 7'h7F, 1'b1, 1'b1);
    // program change then note: only the note pulses
    add(1'b1, 8'hC0, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h05, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h90, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h30, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h7F, 7'h30, 7'h7F, 1'b1, 1'b1);
    // sysex data discarded
    add(1'b1, 8'hF0, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h30, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h00, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'hF7, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h30, 7'h30, 7'h7F, 1'b1, 1'b0);
    // explicit note off releases
    add(1'b1, 8'h80, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h30, 7'h30, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 8'h40, 7'h30, 7'h7F, 1'b0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl[%0d]", i), tbl[i].f, tbl[i].vol, tbl[i].g, tbl[i].nv);
    end

    // other-channel note: filtered unless omni
    apply(1'b1, 8'h91);
    apply(1'b1, 8'h45);
    apply(1'b1, 8'h22);
`ifdef OMNI_MODE_EN
    chk("chan1_note", 7'h45, 7'h22, 1'b1, 1'b1);
`else
    chk("chan1_note", 7'h30, 7'h7F, 1'b0, 1'b0);
`endif

    // reset mid-message
    apply(1'b1, 8'h90);
    apply(1'b1, 8'h30);
    @(negedge clk);
    do_reset();
    apply(1'b1, 8'h7F);
    chk("post_reset_d", 7'd69, 7'd0, 1'b0, 1'b0);
    apply(1'b1, 8'h45);
    chk("post_reset_d2", 7'd69, 7'd0, 1'b0, 1'b0);
    apply(1'b1, 8'h90);
    apply(1'b1, 8'h45);
    apply(1'b1, 8'h64);
    chk("post_reset_note", 7'h45, 7'h64, 1'b1, 1'b1);

    // random streams against the reference model
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      apply(($urandom_range(0, 3) != 0), rand_byte());
      chk($sformatf("rand[%0d]", i), m_freq, m_vol, m_gate, m_nv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
